n4_serial_tx: RTL

- 4-bit parallel-to-serial transmitter, upstream of a serial 4-bit right-shift stage.
- Accepts a 4-bit word from a producer through a dav_/rfd handshake.
- Holds the word in an internal right-shift register and drives it on a single line, LSB first, framed by a start bit (0) and stop bit(s) (1).
- The line idles at 1, so a downstream right-shift receiver can sample it bit by bit.

---
 rtl/n4_serial_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/n4_serial_tx.sv
// n4_serial_tx -- 4-bit parallel-to-serial transmitter.
//
// Takes one 4-bit word from a producer and sends it on a single line,
// LSB first, as: start bit (0), d0, d1, d2, d3, then STOP_BITS stop
// bits (1). Every line bit is held for BIT_CYCLES clocks. The line
// idles at 1.
//
// Parameters:
//   BIT_CYCLES  clocks per line bit (1..255)
//   STOP_BITS   stop bits after d3 (1..3)
//
// Ports:
//   clock   in   system clock, rising edge
//   reset_  in   asynchronous reset, active low
//   x3_x0   in   [3:0] data word, sampled only when it is accepted
//   dav_    in   data valid, active low
//   rfd     out  ready for data, high only in IDLE
//   out     out  serial line, 1 when idle
//   busy    out  high from acceptance to the end of the last stop bit
//
// Handshake: in IDLE (rfd=1) a posedge that sees dav_=0 accepts x3_x0
// and drops rfd. rfd only returns to 1 after the frame has ended and
// dav_ has been seen high, so a word held on dav_=0 is sent once.
//
// All outputs are registers; nothing passes combinationally from an
// input to an output.

module n4_serial_tx #(
   parameter int BIT_CYCLES = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic [3:0] x3_x0,
   input  logic       dav_,
   output logic       rfd,
   output logic       out,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_DATA     = 3'd2,
      S_STOP     = 3'd3,
      S_WAIT_REL = 3'd4
   } state_t;

   localparam logic [7:0] PC_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [1:0] SB_LAST = 2'(STOP_BITS - 1);

   state_t     state, state_nx;
   logic [3:0] sr, sr_nx;
   logic [1:0] bcnt, bcnt_nx;
   logic [7:0] pcnt, pcnt_nx;
   logic       rfd_nx, out_nx, busy_nx;
   logic       bit_end;

   // Last clock of the current line bit.
   assign bit_end = (pcnt == PC_LAST);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state <= S_IDLE;
         sr    <= 4'd0;
         bcnt  <= 2'd0;
         pcnt  <= 8'd0;
         rfd   <= 1'b1;
         out   <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         sr    <= sr_nx;
         bcnt  <= bcnt_nx;
         pcnt  <= pcnt_nx;
         rfd   <= rfd_nx;
         out   <= out_nx;
         busy  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      bcnt_nx  = bcnt;
      pcnt_nx  = pcnt;
      rfd_nx   = rfd;
      out_nx   = out;
      busy_nx  = busy;

      case (state)
         S_IDLE: begin
            if (!dav_) begin
               sr_nx    = x3_x0;
               rfd_nx   = 1'b0;
               busy_nx  = 1'b1;
               out_nx   = 1'b0;
               pcnt_nx  = 8'd0;
               bcnt_nx  = 2'd0;
               state_nx = S_START;
            end
         end

         S_START: begin
            if (bit_end) begin
               pcnt_nx  = 8'd0;
               out_nx   = sr[0];
               bcnt_nx  = 2'd0;
               state_nx = S_DATA;
            end else begin
               pcnt_nx = pcnt + 8'd1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               pcnt_nx = 8'd0;
               if (bcnt == 2'd3) begin
                  out_nx   = 1'b1;
                  bcnt_nx  = 2'd0;
                  state_nx = S_STOP;
               end else begin
                  // Shift right; the bit that lands in sr[0] is sr[1] now.
                  sr_nx   = {1'b0, sr[3:1]};
                  out_nx  = sr[1];
                  bcnt_nx = bcnt + 2'd1;
               end
            end else begin
               pcnt_nx = pcnt + 8'd1;
            end
         end

         S_STOP: begin
            // bcnt is reused here to count stop bits.
            if (bit_end) begin
               pcnt_nx = 8'd0;
               if (bcnt == SB_LAST) begin
                  busy_nx  = 1'b0;
                  bcnt_nx  = 2'd0;
                  state_nx = S_WAIT_REL;
               end else begin
                  bcnt_nx = bcnt + 2'd1;
               end
            end else begin
               pcnt_nx = pcnt + 8'd1;
            end
         end

         S_WAIT_REL: begin
            if (dav_) begin
               rfd_nx   = 1'b1;
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
            rfd_nx   = 1'b1;
            out_nx   = 1'b1;
            busy_nx  = 1'b0;
         end
      endcase
   end

endmodule
